// File: rtl/ps2_ascii_source_pkg.sv
// ps2_pkg: frame/decoder FSM states, scan-code prefixes and the set-2 to ASCII lookup
// shared by ps2_ascii_source and Ps2FrameRx.
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_NORMAL,
    DEC_BREAK,
    DEC_EXT,
    DEC_EXT_BREAK
  } dec_state_t;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  // Returns {valid, ascii}; letters are looked up lowercase and folded to uppercase on shift.
  function automatic logic [8:0] scan_to_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] ch;
    logic       valid;
    ch    = 8'h00;
    valid = 1'b1;
    case (code)
      8'h1C: ch = "a";
      8'h32: ch = "b";
      8'h21: ch = "c";
      8'h23: ch = "d";
      8'h24: ch = "e";
      8'h2B: ch = "f";
      8'h34: ch = "g";
      8'h33: ch = "h";
      8'h43: ch = "i";
      8'h3B: ch = "j";
      8'h42: ch = "k";
      8'h4B: ch = "l";
      8'h3A: ch = "m";
      8'h31: ch = "n";
      8'h44: ch = "o";
      8'h4D: ch = "p";
      8'h15: ch = "q";
      8'h2D: ch = "r";
      8'h1B: ch = "s";
      8'h2C: ch = "t";
      8'h3C: ch = "u";
      8'h2A: ch = "v";
      8'h1D: ch = "w";
      8'h22: ch = "x";
      8'h35: ch = "y";
      8'h1A: ch = "z";
      8'h16: ch = shift ? "!" : "1";
      8'h1E: ch = shift ? "@" : "2";
      8'h26: ch = shift ? "#" : "3";
      8'h25: ch = shift ? "$" : "4";
      8'h2E: ch = shift ? "%" : "5";
      8'h36: ch = shift ? "^" : "6";
      8'h3D: ch = shift ? "&" : "7";
      8'h3E: ch = shift ? "*" : "8";
      8'h46: ch = shift ? "(" : "9";
      8'h45: ch = shift ? ")" : "0";
      8'h29: ch = 8'h20;
      8'h5A: ch = 8'h0A;
      8'h66: ch = 8'h08;
      default: valid = 1'b0;
    endcase
    if (shift && (ch >= "a") && (ch <= "z")) begin
      ch = ch - 8'h20;
    end
    return {valid, ch};
  endfunction

endpackage

// File: rtl/ps2_ascii_source_if.sv
// ps2_ascii_source_if: decoded character stream from the PS/2 decoder to the display.
interface ps2_ascii_source_if;
  logic [7:0] ascii;
  logic       ascii_val;
  logic       frame_err;

  modport master (output ascii, ascii_val, frame_err);
  modport slave  (input  ascii, ascii_val, frame_err);
endinterface

// File: rtl/ps2_ascii_source_frame_rx.sv
// Ps2FrameRx: synchronizes the PS/2 pins, detects clock falling edges and assembles
// 11-bit frames into bytes, flagging start/parity/stop/timeout errors.
module Ps2FrameRx
  import ps2_pkg::*;
#(
  parameter int p_timeout_cycles = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_val,
  output logic       frame_err
);

  localparam logic [15:0] TMO_LAST = 16'(p_timeout_cycles - 1);

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;
  logic       fall;
  logic       bit_in;

  rx_state_t  state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] data_sr, data_sr_nxt;
  logic       par_bit, par_bit_nxt;
  logic [15:0] tmo_cnt, tmo_nxt;
  logic [7:0] byte_nxt;
  logic       val_nxt, err_nxt;

  // Pins idle high, so the synchronizers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign bit_in = data_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RX_IDLE;
      bit_cnt   <= 3'd0;
      data_sr   <= 8'h00;
      par_bit   <= 1'b0;
      tmo_cnt   <= 16'd0;
      rx_byte   <= 8'h00;
      byte_val  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      data_sr   <= data_sr_nxt;
      par_bit   <= par_bit_nxt;
      tmo_cnt   <= tmo_nxt;
      rx_byte   <= byte_nxt;
      byte_val  <= val_nxt;
      frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    data_sr_nxt = data_sr;
    par_bit_nxt = par_bit;
    tmo_nxt     = tmo_cnt;
    byte_nxt    = rx_byte;
    val_nxt     = 1'b0;
    err_nxt     = 1'b0;

    // An edge in the same cycle as expiry wins: the timeout branch only runs without one.
    if (state != RX_IDLE) begin
      if (fall) begin
        tmo_nxt = 16'd0;
      end else if (tmo_cnt == TMO_LAST) begin
        tmo_nxt   = 16'd0;
        state_nxt = RX_IDLE;
        err_nxt   = 1'b1;
      end else begin
        tmo_nxt = tmo_cnt + 16'd1;
      end
    end

    if (fall) begin
      unique case (state)
        RX_IDLE: begin
          if (!bit_in) begin
            state_nxt   = RX_DATA;
            bit_cnt_nxt = 3'd0;
          end else begin
            err_nxt = 1'b1;
          end
        end
        RX_DATA: begin
          data_sr_nxt = {bit_in, data_sr[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt = RX_PARITY;
          end
        end
        RX_PARITY: begin
          par_bit_nxt = bit_in;
          state_nxt   = RX_STOP;
        end
        RX_STOP: begin
          state_nxt = RX_IDLE;
          if (bit_in && (^{data_sr, par_bit})) begin
            byte_nxt = data_sr;
            val_nxt  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_ascii_source.sv
// ps2_ascii_source: PS/2 set-2 keyboard decoder producing a one-cycle ASCII stream.
// Define PS2_SHIFT_EN to track Shift and emit uppercase letters and digit-row symbols.
module ps2_ascii_source
  import ps2_pkg::*;
#(
  parameter int p_timeout_cycles = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_ascii_source_if.master bus
);

  logic [7:0] rx_byte;
  logic       byte_val;
  logic       rx_err;

  dec_state_t dec_state, dec_nxt;
  logic [7:0] ascii_q, ascii_nxt;
  logic       ascii_val_q, val_nxt;
  logic       frame_err_q;
  logic [8:0] lookup;
  logic       is_shift;
  logic       shift_on;

  Ps2FrameRx #(
    .p_timeout_cycles(p_timeout_cycles)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_val  (byte_val),
    .frame_err (rx_err)
  );

`ifdef PS2_SHIFT_EN
  logic shift_q, shift_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= 1'b0;
    end else begin
      shift_q <= shift_nxt;
    end
  end

  assign shift_on = shift_q;
`else
  assign shift_on = 1'b0;
`endif

  assign is_shift = (rx_byte == PS2_LSHIFT) || (rx_byte == PS2_RSHIFT);
  assign lookup   = scan_to_ascii(rx_byte, shift_on);

  // frame_err is re-registered so it lines up with ascii_val one stage behind the receiver.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_state   <= DEC_NORMAL;
      ascii_q     <= 8'h00;
      ascii_val_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      dec_state   <= dec_nxt;
      ascii_q     <= ascii_nxt;
      ascii_val_q <= val_nxt;
      frame_err_q <= rx_err;
    end
  end

  always_comb begin
    dec_nxt   = dec_state;
    ascii_nxt = ascii_q;
    val_nxt   = 1'b0;
`ifdef PS2_SHIFT_EN
    shift_nxt = shift_q;
`endif
    if (byte_val) begin
      unique case (dec_state)
        DEC_NORMAL: begin
          if (rx_byte == PS2_BREAK) begin
            dec_nxt = DEC_BREAK;
          end else if (rx_byte == PS2_EXT) begin
            dec_nxt = DEC_EXT;
          end else if (is_shift) begin
`ifdef PS2_SHIFT_EN
            shift_nxt = 1'b1;
`endif
          end else if (lookup[8]) begin
            ascii_nxt = lookup[7:0];
            val_nxt   = 1'b1;
          end
        end
        DEC_BREAK: begin
`ifdef PS2_SHIFT_EN
          if (is_shift) begin
            shift_nxt = 1'b0;
          end
`endif
          dec_nxt = DEC_NORMAL;
        end
        DEC_EXT: begin
          dec_nxt = (rx_byte == PS2_BREAK) ? DEC_EXT_BREAK : DEC_NORMAL;
        end
        DEC_EXT_BREAK: dec_nxt = DEC_NORMAL;
        default:       dec_nxt = DEC_NORMAL;
      endcase
    end
  end

  assign bus.ascii     = ascii_q;
  assign bus.ascii_val = ascii_val_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_ascii_source.sv
// tb_ps2_ascii_source: drives PS/2 frames into ps2_ascii_source and compares the ASCII
// stream and error pulses against a key-table keyboard model.
module tb_ps2_ascii_source;

  localparam int TMO  = 100;
  localparam int HALF = 16;
`ifdef PS2_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic ps2_clk;
  logic ps2_data;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] obs_q[$];
  int         obs_cyc[$];
  int         err_total = 0;
  int         err_cyc = 0;
  logic [7:0] exp_q[$];

  logic [7:0] plain_map[logic [7:0]];
  logic [7:0] shift_map[logic [7:0]];
  bit m_shift, m_break, m_ext;

  ps2_ascii_source_if bus ();

  ps2_ascii_source #(
    .p_timeout_cycles(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor records every output pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (bus.ascii_val === 1'b1) begin
      obs_q.push_back(bus.ascii);
      obs_cyc.push_back(cyc);
    end
    if (bus.frame_err === 1'b1) begin
      err_total++;
      err_cyc = cyc;
    end
  end

  task automatic build_maps();
    string letters, digits, syms;
    logic [7:0] lc[26];
    logic [7:0] dc[10];
    logic [7:0] ch;
    letters = "abcdefghijklmnopqrstuvwxyz";
    digits  = "1234567890";
    syms    = "!@#$%^&*()";
    lc = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
           8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    dc = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    for (int i = 0; i < 26; i++) begin
      ch = letters[i];
      plain_map[lc[i]] = ch;
      shift_map[lc[i]] = ch - 8'h20;
    end
    for (int i = 0; i < 10; i++) begin
      ch = digits[i];
      plain_map[dc[i]] = ch;
      ch = syms[i];
      shift_map[dc[i]] = ch;
    end
    plain_map[8'h29] = 8'h20; shift_map[8'h29] = 8'h20;
    plain_map[8'h5A] = 8'h0A; shift_map[8'h5A] = 8'h0A;
    plain_map[8'h66] = 8'h08; shift_map[8'h66] = 8'h08;
  endtask

  // Keyboard model: a prefix byte arms a flag that the following byte consumes.
  task automatic model_byte(input logic [7:0] b);
    bit is_sh;
    is_sh = (b == 8'h12) || (b == 8'h59);
    if (m_break) begin
      if (SHIFT_EN && is_sh && !m_ext) m_shift = 1'b0;
      m_break = 1'b0;
      m_ext   = 1'b0;
    end else if (b == 8'hF0) m_break = 1'b1;
    else if (m_ext) m_ext = 1'b0;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (is_sh) m_shift = SHIFT_EN;
    else if (m_shift && shift_map.exists(b)) exp_q.push_back(shift_map[b]);
    else if (!m_shift && plain_map.exists(b)) exp_q.push_back(plain_map[b]);
  endtask

  task automatic send_bit(input logic v, output int fall_cyc);
    @(negedge clk);
    ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_parity, input int nbits,
                            output int last_fall);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    last_fall = 0;
    for (int i = 0; i < nbits; i++) send_bit(bits[i], last_fall);
  endtask

  task automatic test_reset();
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.ascii !== 8'h00) begin failures++; $display("[TB] FAIL reset_ascii got=%h exp=00", bus.ascii); end
    checks++;
    if (bus.ascii_val !== 1'b0) begin failures++; $display("[TB] FAIL reset_ascii_val got=%b exp=0", bus.ascii_val); end
    checks++;
    if (bus.frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (err_total !== 0 || obs_q.size() !== 0) begin
      failures++; $display("[TB] FAIL reset_quiet got errs=%0d chars=%0d exp=0/0", err_total, obs_q.size());
    end
  endtask

  task automatic test_single_char();
    int base, ebase, fall;
    base = obs_q.size(); ebase = err_total; exp_q.delete();
    send_frame(8'h1C, 1'b0, 11, fall);
    model_byte(8'h1C);
    repeat (8) @(negedge clk);
    checks++;
    if (obs_q.size() - base !== 1) begin
      failures++; $display("[TB] FAIL single_count got=%0d exp=1", obs_q.size() - base);
    end else begin
      checks++;
      if (obs_q[base] !== exp_q[0]) begin failures++; $display("[TB] FAIL single_value got=%h exp=%h", obs_q[base], exp_q[0]); end
      checks++;
      if (obs_cyc[base] !== fall + 4) begin failures++; $display("[TB] FAIL single_latency got=%0d exp=%0d", obs_cyc[base], fall + 4); end
    end
    checks++;
    if (err_total - ebase !== 0) begin failures++; $display("[TB] FAIL single_err got=%0d exp=0", err_total - ebase); end
    checks++;
    if (bus.ascii !== 8'h61) begin failures++; $display("[TB] FAIL single_hold got=%h exp=61", bus.ascii); end
  endtask

  task automatic test_sequence(input string name, input logic [7:0] seq[$]);
    int base, fall;
    base = obs_q.size(); exp_q.delete();
    foreach (seq[i]) begin
      send_frame(seq[i], 1'b0, 11, fall);
      model_byte(seq[i]);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (obs_q.size() - base !== exp_q.size()) begin
      failures++; $display("[TB] FAIL %s_count got=%0d exp=%0d", name, obs_q.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[base + i] !== exp_q[i]) begin
          failures++; $display("[TB] FAIL %s_char%0d got=%h exp=%h", name, i, obs_q[base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_parity_err();
    int base, ebase, fall;
    base = obs_q.size(); ebase = err_total; exp_q.delete();
    send_frame(8'h1C, 1'b1, 11, fall);
    repeat (8) @(negedge clk);
    checks++;
    if (err_total - ebase !== 1) begin failures++; $display("[TB] FAIL parity_err_count got=%0d exp=1", err_total - ebase); end
    checks++;
    if (err_cyc !== fall + 4) begin failures++; $display("[TB] FAIL parity_err_latency got=%0d exp=%0d", err_cyc, fall + 4); end
    checks++;
    if (obs_q.size() - base !== 0) begin failures++; $display("[TB] FAIL parity_no_char got=%0d exp=0", obs_q.size() - base); end
    send_frame(8'h45, 1'b0, 11, fall);
    model_byte(8'h45);
    repeat (8) @(negedge clk);
    checks++;
    if (obs_q.size() - base !== 1 || exp_q.size() !== 1) begin
      failures++; $display("[TB] FAIL parity_recover_count got=%0d exp=%0d", obs_q.size() - base, exp_q.size());
    end else if (obs_q[base] !== exp_q[0]) begin
      failures++; $display("[TB] FAIL parity_recover_value got=%h exp=%h", obs_q[base], exp_q[0]);
    end
  endtask

  task automatic test_timeout();
    int base, ebase, fall;
    base = obs_q.size(); ebase = err_total; exp_q.delete();
    send_frame(8'hA5, 1'b0, 6, fall);
    repeat (TMO + 20) @(negedge clk);
    checks++;
    if (err_total - ebase !== 1) begin failures++; $display("[TB] FAIL timeout_err_count got=%0d exp=1", err_total - ebase); end
    checks++;
    if (err_cyc < fall + TMO || err_cyc > fall + TMO + 10) begin
      failures++; $display("[TB] FAIL timeout_latency got=%0d exp=%0d..%0d", err_cyc, fall + TMO, fall + TMO + 10);
    end
    send_frame(8'h29, 1'b0, 11, fall);
    model_byte(8'h29);
    repeat (8) @(negedge clk);
    checks++;
    if (obs_q.size() - base !== 1 || exp_q.size() !== 1) begin
      failures++; $display("[TB] FAIL timeout_recover_count got=%0d exp=%0d", obs_q.size() - base, exp_q.size());
    end else if (obs_q[base] !== exp_q[0]) begin
      failures++; $display("[TB] FAIL timeout_recover_value got=%h exp=%h", obs_q[base], exp_q[0]);
    end
    checks++;
    if (err_total - ebase !== 1) begin failures++; $display("[TB] FAIL timeout_extra_err got=%0d exp=1", err_total - ebase); end
  endtask

  task automatic test_random();
    logic [7:0] pool[14];
    int base, ebase, fall, exp_err;
    pool = '{8'h1C, 8'h12, 8'h59, 8'hF0, 8'hE0, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h1A, 8'h3E, 8'h75, 8'h4D};
    base = obs_q.size(); ebase = err_total; exp_q.delete(); exp_err = 0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      bit bad;
      if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
      else b = pool[$urandom_range(0, 13)];
      bad = ($urandom_range(0, 9) == 0);
      send_frame(b, bad, 11, fall);
      if (bad) exp_err++;
      else model_byte(b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (err_total - ebase !== exp_err) begin
      failures++; $display("[TB] FAIL random_err_count got=%0d exp=%0d", err_total - ebase, exp_err);
    end
    checks++;
    if (obs_q.size() - base !== exp_q.size()) begin
      failures++; $display("[TB] FAIL random_count got=%0d exp=%0d", obs_q.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[base + i] !== exp_q[i]) begin
          failures++; $display("[TB] FAIL random_char%0d got=%h exp=%h", i, obs_q[base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int base, ebase, fall;
    base = obs_q.size(); ebase = err_total; exp_q.delete();
    send_frame(8'h3C, 1'b0, 5, fall);
    @(negedge clk);
    rst = 1'b0;
    m_shift = 1'b0; m_break = 1'b0; m_ext = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ascii !== 8'h00 || bus.ascii_val !== 1'b0 || bus.frame_err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midreset_outputs got=%h/%b/%b exp=00/0/0", bus.ascii, bus.ascii_val, bus.frame_err);
      end
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, 1'b0, 11, fall);
    model_byte(8'h5A);
    repeat (8) @(negedge clk);
    checks++;
    if (obs_q.size() - base !== 1 || exp_q.size() !== 1) begin
      failures++; $display("[TB] FAIL midreset_count got=%0d exp=%0d", obs_q.size() - base, exp_q.size());
    end else if (obs_q[base] !== exp_q[0]) begin
      failures++; $display("[TB] FAIL midreset_value got=%h exp=%h", obs_q[base], exp_q[0]);
    end
    checks++;
    if (err_total - ebase !== 0) begin failures++; $display("[TB] FAIL midreset_err got=%0d exp=0", err_total - ebase); end
  endtask

  initial begin
    logic [7:0] seq[$];
    build_maps();
    m_shift = 1'b0; m_break = 1'b0; m_ext = 1'b0;
    test_reset();
    test_single_char();
    seq = '{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    test_sequence("shift", seq);
    seq = '{8'hF0, 8'h1C};
    test_sequence("break", seq);
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    test_sequence("ext", seq);
    seq = '{8'h59, 8'h1E, 8'h4D, 8'h29, 8'hF0, 8'h59, 8'h1E, 8'h66, 8'h5A};
    test_sequence("back_to_back", seq);
    test_parity_err();
    test_timeout();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
